// File: rtl/bsg_corner_turn.sv
// bsg_corner_turn: sequential matrix transpose; accepts els_p rows of width_p elements, then emits width_p columns
module bsg_corner_turn #(
    parameter int width_p      = 3,
    parameter int els_p        = 4,
    parameter int type_width_p = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            v_i,
    input  logic [width_p*type_width_p-1:0] data_i,
    output logic                            ready_and_o,
    output logic                            v_o,
    output logic [els_p*type_width_p-1:0]   data_o,
    output logic                            last_o,
    input  logic                            yumi_i
);
    localparam int rw = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cw = (width_p > 1) ? $clog2(width_p) : 1;

    typedef enum logic {s_fill, s_drain} state_t;

    state_t                  state, state_n;
    logic [rw-1:0]           row_cnt, row_n;
    logic [cw-1:0]           col_cnt, col_n;
    logic [type_width_p-1:0] mem [els_p][width_p];
    logic                    row_last, col_last;

    assign row_last    = row_cnt == rw'(els_p - 1);
    assign col_last    = col_cnt == cw'(width_p - 1);
    assign ready_and_o = state == s_fill;
    assign v_o         = state == s_drain;
    assign last_o      = v_o && col_last;

    always_comb begin
        state_n = state;
        row_n   = row_cnt;
        col_n   = col_cnt;
        if (ready_and_o && v_i) begin
            row_n   = row_last ? '0 : row_cnt + 1'b1;
            state_n = row_last ? s_drain : s_fill;
        end
        if (v_o && yumi_i) begin
            col_n   = col_last ? '0 : col_cnt + 1'b1;
            state_n = col_last ? s_fill : s_drain;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= s_fill;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state   <= state_n;
            row_cnt <= row_n;
            col_cnt <= col_n;
        end
    end

    // storage is deliberately unreset; a matrix is only read after being fully written
    always_ff @(posedge clk_i) begin
        if (ready_and_o && v_i)
            for (int y = 0; y < width_p; y++)
                mem[row_cnt][y] <= data_i[y*type_width_p +: type_width_p];
    end

    always_comb begin
        data_o = '0;
        for (int x = 0; x < els_p; x++)
            data_o[x*type_width_p +: type_width_p] = mem[x][col_cnt];
    end
endmodule

// File: tb/tb_bsg_corner_turn.sv
// tb_bsg_corner_turn: transpose scoreboard for a 4x3 byte matrix plus directed checks on a 1x1 instance
module tb_bsg_corner_turn;
    localparam int W = 3, E = 4, T = 8;

    logic clk = 0, reset_i = 1;
    logic v_i = 0, yumi_i = 0, ready_and_o, v_o, last_o;
    logic [W*T-1:0] data_i = '0;
    logic [E*T-1:0] data_o;
    logic dv_i = 0, dyumi = 0, dready, dv_o, dlast;
    logic [T-1:0] ddata_i = '0, ddata_o;

    int n_cmp = 0, n_fail = 0;

    logic [T-1:0] mmat [E][W];
    int  mrows = 0, mcols = 0, mdone = 0;
    bit  mfill = 1;

    always #5 clk = ~clk;

    bsg_corner_turn #(.width_p(W), .els_p(E), .type_width_p(T)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_and_o(ready_and_o),
        .v_o(v_o), .data_o(data_o), .last_o(last_o), .yumi_i(yumi_i));

    bsg_corner_turn #(.width_p(1), .els_p(1), .type_width_p(T)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .v_i(dv_i), .data_i(ddata_i), .ready_and_o(dready),
        .v_o(dv_o), .data_o(ddata_o), .last_o(dlast), .yumi_i(dyumi));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W*T-1:0] row(input int x);
        logic [W*T-1:0] r;
        for (int y = 0; y < W; y++) r[y*T +: T] = T'(x*16 + y);
        return r;
    endfunction

    // Model: a matrix is either being collected (mfill) or handed out column by column.
    always @(negedge clk) begin
        logic [E*T-1:0] col;
        if (!reset_i) begin
            chk("ready", ready_and_o, mfill);
            chk("v_o", v_o, !mfill);
            chk("last", last_o, !mfill && mcols == W-1);
            if (!mfill) begin
                for (int x = 0; x < E; x++) col[x*T +: T] = mmat[x][mcols];
                chk("column", data_o, col);
            end
            if (yumi_i && !v_o) begin
                n_fail++;
                $display("FAIL yumi_protocol: yumi_i=1 while v_o=0 at %0t", $time);
            end
        end
        if (reset_i) begin
            mfill = 1; mrows = 0; mcols = 0;
        end else if (mfill && v_i) begin
            for (int y = 0; y < W; y++) mmat[mrows][y] = data_i[y*T +: T];
            mrows++;
            if (mrows == E) begin mfill = 0; mcols = 0; end
        end else if (!mfill && yumi_i) begin
            mcols++;
            if (mcols == W) begin mfill = 1; mrows = 0; mdone++; end
        end
    end

    task automatic flush();
        v_i = 0;
        for (int i = 0; i < 20 && !ready_and_o; i++) begin
            yumi_i = v_o;
            tick();
        end
        yumi_i = 0;
        chk("flush_done", ready_and_o, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_col [W];
        int d0, cyc;
        exp_col[0] = 32'h30201000;
        exp_col[1] = 32'h31211101;
        exp_col[2] = 32'h32221202;

        // 1: directed transpose with literal expectations
        tick(); tick();
        reset_i = 0;
        chk("rst_ready", ready_and_o, 1'b1);
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_last", last_o, 1'b0);
        for (int x = 0; x < E; x++) begin
            v_i = 1; data_i = row(x);
            tick();
        end
        v_i = 0; yumi_i = 1;
        for (int c = 0; c < W; c++) begin
            chk("t1_v_o", v_o, 1'b1);
            chk("t1_ready_low", ready_and_o, 1'b0);
            chk("t1_col", data_o, exp_col[c]);
            chk("t1_last", last_o, c == W-1);
            tick();
        end
        yumi_i = 0;
        chk("t1_ready_back", ready_and_o, 1'b1);
        chk("t1_v_o_off", v_o, 1'b0);

        // 3a: reset after two rows discards the partial matrix
        for (int x = 0; x < 2; x++) begin
            v_i = 1; data_i = 24'hAAAAAA;
            tick();
        end
        v_i = 0; reset_i = 1;
        tick();
        reset_i = 0;
        for (int x = 0; x < E; x++) begin
            v_i = 1; data_i = row(x + 4);
            tick();
        end
        v_i = 0;
        chk("t3_col0", data_o, 32'h70605040);
        flush();

        // 3b: reset mid-drain after column 0 taken
        for (int x = 0; x < E; x++) begin
            v_i = 1; data_i = 24'($urandom);
            tick();
        end
        v_i = 0; yumi_i = 1;
        tick();
        yumi_i = 0; reset_i = 1;
        tick();
        reset_i = 0;
        chk("t3_v_o_after_rst", v_o, 1'b0);
        chk("t3_ready_after_rst", ready_and_o, 1'b1);

        // 5: long stall in drain with v_i asserted
        for (int x = 0; x < E; x++) begin
            v_i = 1; data_i = row(x);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            v_i = 1; data_i = 24'($urandom);
            chk("t5_ready", ready_and_o, 1'b0);
            chk("t5_col0", data_o, exp_col[0]);
            tick();
        end
        flush();

        // 6: back-to-back matrices at full rate, E+W cycles each
        d0 = mdone;
        for (int i = 0; i < 3*(E+W); i++) begin
            v_i = 1; data_i = 24'($urandom); yumi_i = v_o;
            tick();
        end
        v_i = 0; yumi_i = 0;
        chk("t6_matrices", mdone - d0, 3);
        flush();

        // 2: random gaps and backpressure over 50 matrices
        d0 = mdone; cyc = 0;
        while (mdone < d0 + 50 && cyc < 20000) begin
            v_i = $urandom_range(0, 2) != 0;
            data_i = 24'($urandom);
            yumi_i = v_o && $urandom_range(0, 1) == 1;
            tick();
            cyc++;
        end
        chk("t2_matrices", mdone - d0, 50);
        flush();

        // 4: 1x1 instance passes each row straight through
        for (int k = 0; k < 5; k++) begin
            logic [T-1:0] val;
            val = T'(8'h3C + k*17);
            chk("t4_ready_hi", dready, 1'b1);
            chk("t4_v_o_lo", dv_o, 1'b0);
            dv_i = 1; ddata_i = val; dyumi = 0;
            tick();
            chk("t4_v_o", dv_o, 1'b1);
            chk("t4_last", dlast, 1'b1);
            chk("t4_data", ddata_o, val);
            chk("t4_ready_lo", dready, 1'b0);
            ddata_i = ~val; dyumi = 1;
            tick();
            dyumi = 0;
        end
        dv_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
